// File: rtl/bus_scenario_sequencer.sv
// Bus-test stimulus sequencer: per-master enable windows, repeat passes with auto-increment, read capture, WAIT timeout.
// Latency: master outputs follow the pass counter by one register stage; m_request stalls WAIT until clear or timeout.
module bus_scenario_sequencer #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 14,
    parameter int DATA_WIDTH     = 8,
    parameter int HOLD_CYCLES    = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [NUM_MASTERS-1:0]            cfg_en,
    input  logic [NUM_MASTERS-1:0]            cfg_rd,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] cfg_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] cfg_data,
    input  logic [NUM_MASTERS*8-1:0]          cfg_delay,
    input  logic [3:0]                        cfg_repeat,
    input  logic                              cfg_inc,
    input  logic [NUM_MASTERS-1:0]            m_request,
    input  logic [NUM_MASTERS-1:0]            m_rvalid,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
    output logic [NUM_MASTERS-1:0]            m_enable,
    output logic [NUM_MASTERS-1:0]            m_read_en,
    output logic [NUM_MASTERS*ADDR_WIDTH-1:0] addr_in,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] data_in,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_MASTERS-1:0]            rd_valid,
    output logic                              busy,
    output logic                              done,
    output logic                              timeout_err,
    output logic [2:0]                        state_out
);

    // Pass counter must reach the largest delay plus the hold window.
    localparam int TW = $clog2(256 + HOLD_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_NEXT   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                  state, state_n;
    logic [NUM_MASTERS-1:0]  en_r, rd_r;
    logic [ADDR_WIDTH-1:0]   addr_r  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]   data_r  [NUM_MASTERS];
    logic [7:0]              delay_r [NUM_MASTERS];
    logic [3:0]              left_r;
    logic                    inc_r;
    logic [TW-1:0]           t_r, last_t;
    logic [15:0]             wcnt_r;
    logic [NUM_MASTERS-1:0]  win;

    always_comb begin
        last_t = '0;
        win    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (en_r[i] && (TW'(delay_r[i]) + TW'(HOLD_CYCLES - 1) > last_t))
                last_t = TW'(delay_r[i]) + TW'(HOLD_CYCLES - 1);
            win[i] = en_r[i] && (t_r >= TW'(delay_r[i])) &&
                     (t_r <= TW'(delay_r[i]) + TW'(HOLD_CYCLES - 1));
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start) state_n = (cfg_en == '0) ? S_DONE : S_LAUNCH;
            S_LAUNCH: if (t_r == last_t) state_n = S_WAIT;
            S_WAIT: begin
                if (m_request == '0)
                    state_n = S_NEXT;
                else if (wcnt_r == 16'(TIMEOUT_CYCLES - 1))
                    state_n = S_DONE;
            end
            S_NEXT:   state_n = (left_r != '0) ? S_LAUNCH : S_DONE;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_n;
    end

    assign state_out = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_r        <= '0;
            rd_r        <= '0;
            left_r      <= '0;
            inc_r       <= 1'b0;
            t_r         <= '0;
            wcnt_r      <= '0;
            m_enable    <= '0;
            m_read_en   <= '0;
            addr_in     <= '0;
            data_in     <= '0;
            rd_data     <= '0;
            rd_valid    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            for (int i = 0; i < NUM_MASTERS; i++) begin
                addr_r[i]  <= '0;
                data_r[i]  <= '0;
                delay_r[i] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        en_r        <= cfg_en;
                        rd_r        <= cfg_rd;
                        left_r      <= cfg_repeat;
                        inc_r       <= cfg_inc;
                        t_r         <= '0;
                        wcnt_r      <= '0;
                        rd_valid    <= '0;
                        timeout_err <= 1'b0;
                        for (int i = 0; i < NUM_MASTERS; i++) begin
                            addr_r[i]  <= cfg_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                            data_r[i]  <= cfg_data[i*DATA_WIDTH +: DATA_WIDTH];
                            delay_r[i] <= cfg_delay[i*8 +: 8];
                        end
                    end
                end
                S_LAUNCH: begin
                    t_r    <= t_r + TW'(1);
                    wcnt_r <= '0;
                end
                S_WAIT: begin
                    wcnt_r <= wcnt_r + 16'd1;
                    if (m_request != '0 && wcnt_r == 16'(TIMEOUT_CYCLES - 1))
                        timeout_err <= 1'b1;
                end
                S_NEXT: begin
                    if (left_r != '0) begin
                        left_r <= left_r - 4'd1;
                        t_r    <= '0;
                        if (inc_r) begin
                            for (int i = 0; i < NUM_MASTERS; i++) begin
                                addr_r[i] <= addr_r[i] + ADDR_WIDTH'(1);
                                data_r[i] <= data_r[i] + DATA_WIDTH'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase

            // Master drive is zero outside each window so idle masters see a clean bus.
            for (int i = 0; i < NUM_MASTERS; i++) begin
                m_enable[i]  <= (state == S_LAUNCH) && win[i];
                m_read_en[i] <= (state == S_LAUNCH) && win[i] && rd_r[i];
                addr_in[i*ADDR_WIDTH +: ADDR_WIDTH] <=
                    ((state == S_LAUNCH) && win[i]) ? addr_r[i] : '0;
                data_in[i*DATA_WIDTH +: DATA_WIDTH] <=
                    ((state == S_LAUNCH) && win[i] && !rd_r[i]) ? data_r[i] : '0;
                if ((state == S_LAUNCH || state == S_WAIT) && m_rvalid[i]) begin
                    rd_data[i*DATA_WIDTH +: DATA_WIDTH] <= m_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                    rd_valid[i] <= 1'b1;
                end
            end

            busy <= (state_n != S_IDLE);
            done <= (state_n == S_DONE);
        end
    end

endmodule

// File: tb/tb_bus_scenario_sequencer.sv
// Bench for bus_scenario_sequencer: expected enable beats and done pulses are queued per run from
// pass-timing arithmetic; a negedge monitor pops and compares whenever the DUT drives them.
module tb_bus_scenario_sequencer;

    localparam int NM   = 2;
    localparam int AW   = 14;
    localparam int DW   = 8;
    localparam int HOLD = 3;
    localparam int TMO  = 255;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [NM-1:0]    cfg_en, cfg_rd;
    logic [NM*AW-1:0] cfg_addr;
    logic [NM*DW-1:0] cfg_data;
    logic [NM*8-1:0]  cfg_delay;
    logic [3:0]       cfg_repeat;
    logic             cfg_inc;
    logic [NM-1:0]    m_request, m_rvalid;
    logic [NM*DW-1:0] m_rdata;
    logic [NM-1:0]    m_enable, m_read_en;
    logic [NM*AW-1:0] addr_in;
    logic [NM*DW-1:0] data_in, rd_data;
    logic [NM-1:0]    rd_valid;
    logic             busy, done, timeout_err;
    logic [2:0]       state_out;

    bus_scenario_sequencer #(
        .NUM_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
        .HOLD_CYCLES(HOLD), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_en(cfg_en), .cfg_rd(cfg_rd), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_delay(cfg_delay), .cfg_repeat(cfg_repeat), .cfg_inc(cfg_inc),
        .m_request(m_request), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .m_enable(m_enable), .m_read_en(m_read_en), .addr_in(addr_in), .data_in(data_in),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .timeout_err(timeout_err), .state_out(state_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        int            m;
        logic          rd;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } beat_t;

    beat_t exp_q[$];
    int    done_q[$];
    beat_t mb;
    int    md;
    int    errors = 0;
    int    checks = 0;
    bit    mon_on = 1'b1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on && reset) begin
            for (int i = 0; i < NM; i++) begin
                checks++;
                if (m_enable[i]) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_enable: master %0d enabled at cyc %0d, none expected", i, cyc);
                    end else begin
                        mb = exp_q.pop_front();
                        if (mb.m != i || mb.cyc != cyc || mb.rd != m_read_en[i] ||
                            mb.addr != addr_in[i*AW +: AW] || mb.data != data_in[i*DW +: DW]) begin
                            errors++;
                            $display("FAIL beat: got m%0d cyc=%0d rd=%0b addr=%0d data=%0d, expected m%0d cyc=%0d rd=%0b addr=%0d data=%0d",
                                     i, cyc, m_read_en[i], addr_in[i*AW +: AW], data_in[i*DW +: DW],
                                     mb.m, mb.cyc, mb.rd, mb.addr, mb.data);
                        end
                    end
                end else if (m_read_en[i] || addr_in[i*AW +: AW] != '0 || data_in[i*DW +: DW] != '0) begin
                    errors++;
                    $display("FAIL idle_drive: master %0d rd=%0b addr=%0d data=%0d, expected all 0",
                             i, m_read_en[i], addr_in[i*AW +: AW], data_in[i*DW +: DW]);
                end
            end
            if (done) begin
                checks++;
                if (done_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done at cyc %0d", cyc);
                end else begin
                    md = done_q.pop_front();
                    if (md != cyc) begin
                        errors++;
                        $display("FAIL done_time: got cyc %0d expected cyc %0d", cyc, md);
                    end
                end
            end
        end
    end

    // One full sequence: queue expectations, drive optional read responses, wait for idle, check sticky results.
    task automatic run_seq(input logic [NM-1:0] en, input logic [NM-1:0] rd,
                           input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                           input logic [7:0] dl0, input logic [7:0] dl1,
                           input logic [3:0] rep, input logic inc,
                           input int rv_mode, input bit tmo, input string name);
        int            c0, L, P, npass, budget, o;
        int            dl [NM];
        logic [AW-1:0] aa [NM];
        logic [DW-1:0] dd [NM];
        logic [DW-1:0] cap_d [NM];
        logic [NM-1:0] cap_v;
        beat_t         b;
        bit            fin;

        dl[0] = int'(dl0); dl[1] = int'(dl1);
        aa[0] = a0; aa[1] = a1; dd[0] = d0; dd[1] = d1;
        cap_v = '0; cap_d[0] = '0; cap_d[1] = '0;

        @(negedge clk);
        cfg_en = en; cfg_rd = rd; cfg_addr = {a1, a0}; cfg_data = {d1, d0};
        cfg_delay = {dl1, dl0}; cfg_repeat = rep; cfg_inc = inc;
        m_request = tmo ? '1 : '0;
        start = 1'b1;
        c0 = cyc + 1;

        L = 0;
        for (int i = 0; i < NM; i++)
            if (en[i] && dl[i] + HOLD - 1 > L) L = dl[i] + HOLD - 1;
        P = L + 3;
        npass = tmo ? 1 : int'(rep) + 1;

        if (en == '0) begin
            done_q.push_back(c0);
            budget = 10;
        end else begin
            for (int k = 0; k < npass; k++)
                for (int t = 0; t <= L; t++)
                    for (int i = 0; i < NM; i++)
                        if (en[i] && t >= dl[i] && t < dl[i] + HOLD) begin
                            b.cyc  = c0 + k * P + 1 + t;
                            b.m    = i;
                            b.rd   = rd[i];
                            b.addr = aa[i] + AW'(inc ? k : 0);
                            b.data = rd[i] ? '0 : dd[i] + DW'(inc ? k : 0);
                            exp_q.push_back(b);
                        end
            done_q.push_back(tmo ? c0 + L + 1 + TMO : c0 + npass * P);
            budget = tmo ? L + TMO + 40 : npass * P + 20;
        end

        fin = 1'b0;
        for (int n = 0; n <= budget && !fin; n++) begin
            if (n > 0) begin
                @(negedge clk);
                start = 1'b0;
                if (n == 1) begin
                    cfg_en = NM'($urandom); cfg_rd = NM'($urandom); cfg_addr = (NM*AW)'($urandom);
                    cfg_data = (NM*DW)'($urandom); cfg_delay = (NM*8)'($urandom);
                    cfg_repeat = 4'($urandom); cfg_inc = 1'($urandom);
                    chk({name, "_busy_after_start"}, 64'(busy), 64'd1);
                    chk({name, "_rd_valid_cleared"}, 64'(rd_valid), 64'd0);
                end
                if (tmo && cyc == c0 + L + 50) start = 1'b1;
                if (!busy) fin = 1'b1;
            end
            if (!fin) begin
                if (rv_mode == 1) begin
                    m_rvalid = NM'($urandom) & NM'($urandom);
                    m_rdata  = (NM*DW)'($urandom);
                end else if (rv_mode == 2 && cyc == c0) begin
                    m_rvalid = '1;
                    m_rdata  = {8'h3C, 8'hA5};
                end else begin
                    m_rvalid = '0;
                end
                o = cyc + 1 - c0;
                if (en != '0 && o >= 1 && o <= (npass - 1) * P + L + 2 && (o % P) != 0)
                    for (int i = 0; i < NM; i++)
                        if (m_rvalid[i]) begin
                            cap_v[i] = 1'b1;
                            cap_d[i] = m_rdata[i*DW +: DW];
                        end
            end
        end
        start = 1'b0; m_rvalid = '0; m_request = '0;

        if (!fin) begin
            checks++; errors++;
            $display("FAIL %s_idle_wait: busy still %0b after %0d cycles, expected 0", name, busy, budget);
        end
        chk({name, "_beats_left"}, 64'(exp_q.size()), 64'd0);
        chk({name, "_dones_left"}, 64'(done_q.size()), 64'd0);
        exp_q.delete(); done_q.delete();
        chk({name, "_timeout_err"}, 64'(timeout_err), 64'(tmo));
        chk({name, "_rd_valid"}, 64'(rd_valid), 64'(cap_v));
        for (int i = 0; i < NM; i++)
            if (cap_v[i]) chk({name, "_rd_data"}, 64'(rd_data[i*DW +: DW]), 64'(cap_d[i]));
    endtask

    task automatic reset_test();
        @(negedge clk);
        mon_on = 1'b0;
        cfg_en = 2'b11; cfg_rd = 2'b00; cfg_addr = {14'd77, 14'd55}; cfg_data = {8'd9, 8'd8};
        cfg_delay = {8'd20, 8'd0}; cfg_repeat = 4'd1; cfg_inc = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 10 && !m_enable[0]; n++) @(negedge clk);
        chk("rst_pre_enable", 64'(m_enable[0]), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst_async_enable", 64'(m_enable), 64'd0);
        chk("rst_async_addr", 64'(addr_in), 64'd0);
        chk("rst_async_busy", 64'(busy), 64'd0);
        chk("rst_async_state", 64'(state_out), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        mon_on = 1'b1;
        repeat (30) @(negedge clk);
        chk("rst_stays_idle", 64'(busy), 64'd0);
    endtask

    logic [NM-1:0] r_en;
    logic [7:0]    r_dl0, r_dl1;

    initial begin
        reset = 1'b0; start = 1'b0;
        cfg_en = '0; cfg_rd = '0; cfg_addr = '0; cfg_data = '0; cfg_delay = '0;
        cfg_repeat = '0; cfg_inc = 1'b0; m_request = '0; m_rvalid = '0; m_rdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_enable", 64'(m_enable), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_state", 64'(state_out), 64'd0);
        chk("reset_rd_valid", 64'(rd_valid), 64'd0);
        chk("reset_timeout", 64'(timeout_err), 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        run_seq(2'b01, 2'b00, 14'd1001, 14'd0, 8'd101, 8'd0, 8'd0, 8'd0, 4'd0, 1'b0, 0, 1'b0, "write_single");
        run_seq(2'b11, 2'b01, 14'd5097, 14'd1001, 8'h11, 8'h22, 8'd0, 8'd8, 4'd0, 1'b0, 0, 1'b0, "staggered");
        run_seq(2'b01, 2'b00, 14'd16383, 14'd0, 8'd255, 8'd0, 8'd0, 8'd0, 4'd2, 1'b1, 0, 1'b0, "repeat_wrap");
        run_seq(2'b11, 2'b11, 14'd10, 14'd20, 8'd0, 8'd0, 8'd0, 8'd1, 4'd0, 1'b0, 2, 1'b0, "read_capture");
        run_seq(2'b01, 2'b00, 14'd300, 14'd0, 8'd7, 8'd0, 8'd0, 8'd0, 4'd2, 1'b1, 0, 1'b1, "timeout");
        run_seq(2'b10, 2'b00, 14'd0, 14'd42, 8'd0, 8'd43, 8'd0, 8'd2, 4'd0, 1'b0, 0, 1'b0, "after_timeout");
        run_seq(2'b00, 2'b11, 14'd1, 14'd2, 8'd3, 8'd4, 8'd5, 8'd6, 4'd3, 1'b1, 0, 1'b0, "no_masters");
        reset_test();
        run_seq(2'b11, 2'b10, 14'd16382, 14'd7, 8'd254, 8'd1, 8'd3, 8'd3, 4'd1, 1'b1, 1, 1'b0, "post_reset");

        for (int r = 0; r < 20; r++) begin
            r_en  = NM'($urandom_range(0, 3));
            r_dl0 = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            r_dl1 = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
            run_seq(r_en, NM'($urandom), AW'($urandom), AW'($urandom), DW'($urandom), DW'($urandom),
                    r_dl0, r_dl1, 4'($urandom_range(0, 3)), 1'($urandom), 1, 1'b0, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
